// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: accepts shift/load commands over a valid/ready handshake
// and drives s/value/MSB/LSB of a universal shift register for the required
// number of cycles, reading Q back to source rotate/arithmetic serial bits.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables ROR (op 3) and ROL (op 4);
// without it those ops are rejected like any other illegal op.
module shift_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] Q_in,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] value,
    output logic             MSB,
    output logic             LSB,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic             fill_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             legal;
    logic [CNT_W-1:0] load_cnt;

    assign cmd_ready = (state == IDLE) && !Clear;
    assign accept    = cmd_valid && cmd_ready;

    // Decode legality and the number of register cycles the offered command needs
    always_comb begin
        legal    = 1'b0;
        load_cnt = '0;
        case (cmd_op)
            OP_LOAD, OP_SHR, OP_SHL, OP_ASR: legal = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR, OP_ROL:                  legal = 1'b1;
`endif
            default:                         legal = 1'b0;
        endcase
        if (legal) begin
            if (cmd_op == OP_LOAD) load_cnt = CNT_W'(1);
            else                   load_cnt = cmd_count;
        end
    end

    // State register; Clear aborts any command in flight
    always_ff @(posedge CLK) begin
        if (Clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus register mode and serial inputs (serial bits track Q_in live)
    always_comb begin
        state_nxt = state;
        s         = 2'b00;
        MSB       = 1'b0;
        LSB       = 1'b0;
        case (state)
            IDLE: begin
                // zero-cycle commands complete without ever leaving IDLE
                if (accept && load_cnt != '0) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == CNT_W'(1)) state_nxt = IDLE;
                case (op_q)
                    OP_LOAD: s = 2'b11;
                    OP_SHR:  begin s = 2'b01; MSB = fill_q;         end
                    OP_SHL:  begin s = 2'b10; LSB = fill_q;         end
                    OP_ROR:  begin s = 2'b01; MSB = Q_in[0];        end
                    OP_ROL:  begin s = 2'b10; LSB = Q_in[WIDTH-1];  end
                    OP_ASR:  begin s = 2'b01; MSB = Q_in[WIDTH-1];  end
                    default: s = 2'b00;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, remaining-cycle counter and the done/err pulses
    always_ff @(posedge CLK) begin
        if (Clear) begin
            value  <= '0;
            op_q   <= '0;
            fill_q <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                op_q   <= cmd_op;
                fill_q <= cmd_fill;
                value  <= cmd_data;
                cnt    <= load_cnt;
                if (load_cnt == '0) begin
                    done <= 1'b1;
                    err  <= !legal;
                end
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: a behavioural shift register closes the Q loop,
// and a transaction-level model turns each accepted command into a script of
// expected per-cycle outputs that is compared against the DUT every cycle.
module tb_shift_cmd_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic          cmd_fill;
    logic [W-1:0]  q_reg = '0;
    logic [1:0]    s;
    logic [W-1:0]  value;
    logic          MSB, LSB, done, err;

    shift_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .Clear(Clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .cmd_fill(cmd_fill), .Q_in(q_reg), .s(s), .value(value),
        .MSB(MSB), .LSB(LSB), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // The universal shift register being sequenced
    always @(posedge CLK) begin
        case (s)
            2'b01:   q_reg <= {MSB, q_reg[W-1:1]};
            2'b10:   q_reg <= {q_reg[W-2:0], LSB};
            2'b11:   q_reg <= value;
            default: q_reg <= q_reg;
        endcase
    end

    typedef struct packed {
        logic [1:0]   s;
        logic         msb, lsb, done, err, busy, upd;
        logic [W-1:0] qn;
    } rec_t;

    rec_t         sched[$];
    logic [W-1:0] exp_q     = '0;
    logic [W-1:0] exp_value = '0;
    bit           last_acc, last_done;
    int           tests = 0;
    int           fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit op_legal(input logic [2:0] op);
        if (op == 3'd3 || op == 3'd4) return ROT_EN;
        return op <= 3'd5;
    endfunction

    // Expand an accepted command into its expected cycle-by-cycle script
    task automatic build(input logic [2:0] op, input logic [W-1:0] d,
                         input logic [CW-1:0] c, input logic f);
        int           n;
        logic [W-1:0] q;
        rec_t         r;
        n = !op_legal(op) ? 0 : (op == 3'd0) ? 1 : int'(c);
        q = exp_q;
        for (int k = 0; k < n; k++) begin
            r = '0;
            r.busy = 1'b1;
            r.upd  = 1'b1;
            case (op)
                3'd0: begin r.s = 2'b11; q = d; end
                3'd1: begin r.s = 2'b01; r.msb = f;      q = {f, q[W-1:1]}; end
                3'd2: begin r.s = 2'b10; r.lsb = f;      q = {q[W-2:0], f}; end
                3'd3: begin r.s = 2'b01; r.msb = q[0];   q = {q[0], q[W-1:1]}; end
                3'd4: begin r.s = 2'b10; r.lsb = q[W-1]; q = {q[W-2:0], q[W-1]}; end
                default: begin r.s = 2'b01; r.msb = q[W-1]; q = {q[W-1], q[W-1:1]}; end
            endcase
            r.qn = q;
            sched.push_back(r);
        end
        r = '0;
        r.done = 1'b1;
        r.err  = !op_legal(op);
        sched.push_back(r);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        rec_t cur;
        bit   exp_rdy;
        @(negedge CLK);
        cur = '0;
        if (sched.size() > 0) cur = sched[0];
        exp_rdy = !cur.busy && !Clear;
        chk("s",         32'(s),         32'(cur.s));
        chk("MSB",       32'(MSB),       32'(cur.msb));
        chk("LSB",       32'(LSB),       32'(cur.lsb));
        chk("done",      32'(done),      32'(cur.done));
        chk("err",       32'(err),       32'(cur.err));
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        chk("value",     32'(value),     32'(exp_value));
        chk("Q",         32'(q_reg),     32'(exp_q));
        last_acc  = cmd_valid && exp_rdy;
        last_done = cur.done;
        @(posedge CLK);
        if (sched.size() > 0) void'(sched.pop_front());
        if (cur.upd) exp_q = cur.qn;
        if (Clear) begin
            sched.delete();
            exp_value = '0;
        end else if (last_acc) begin
            build(cmd_op, cmd_data, cmd_count, cmd_fill);
            exp_value = cmd_data;
        end
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d,
                           input logic [CW-1:0] c, input logic f);
        int k;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c; cmd_fill = f;
        for (k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        cmd_valid = 1'b0;
        chk("accept_bound", 32'(k < 20), 32'd1);
        for (k = 0; k < 20; k++) begin
            cycle();
            if (last_done) break;
        end
        chk("done_bound", 32'(k < 20), 32'd1);
    endtask

    initial begin
        int acc_n, done_n, k;
        Clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        cmd_count = '0; cmd_fill = 1'b0;
        @(posedge CLK); #1;
        cycle();                       // Clear cycle: ready low, outputs reset
        Clear = 1'b0;
        cycle();                       // ready back high

        run_cmd(3'd0, 4'b1010, 3'd0, 1'b0);
        chk("lit_load", 32'(q_reg), 32'(4'b1010));
        run_cmd(3'd1, 4'b0000, 3'd2, 1'b1);
        chk("lit_shr2", 32'(q_reg), 32'(4'b1110));
        run_cmd(3'd0, 4'b1010, 3'd0, 1'b0);
        run_cmd(3'd4, 4'b0000, 3'd1, 1'b0);
        chk("lit_rol1", 32'(q_reg), ROT_EN ? 32'(4'b0101) : 32'(4'b1010));
        run_cmd(3'd0, 4'b1010, 3'd0, 1'b0);
        run_cmd(3'd5, 4'b0000, 3'd3, 1'b0);
        chk("lit_asr3", 32'(q_reg), 32'(4'b1111));
        run_cmd(3'd0, 4'b0110, 3'd0, 1'b0);
        run_cmd(3'd2, 4'b0000, 3'd0, 1'b1);
        chk("lit_shl0", 32'(q_reg), 32'(4'b0110));

        // Clear in the third RUN cycle of a 7-cycle SHL
        run_cmd(3'd0, 4'b1111, 3'd0, 1'b0);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_count = 3'd7; cmd_fill = 1'b0;
        for (k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        cmd_valid = 1'b0;
        cycle(); cycle();
        Clear = 1'b1;
        cycle();
        Clear = 1'b0;
        cycle();
        chk("lit_clear_q", 32'(q_reg), 32'(4'b1000));
        for (int i = 0; i < 4; i++) cycle();

        // Back-to-back: LOAD 0011 then ROR 1 offered immediately
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'b0011; cmd_count = 3'd0;
        for (k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        cmd_op = 3'd3; cmd_count = 3'd1; cmd_data = 4'b0000;
        acc_n = 0; done_n = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (last_acc) begin acc_n = n; cmd_valid = 1'b0; end
            if (last_done && acc_n != 0 && n > acc_n) begin done_n = n; break; end
        end
        chk("b2b_accept_cycle", 32'(acc_n), 32'd2);
        chk("b2b_done_cycle", 32'(done_n), ROT_EN ? 32'd4 : 32'd3);
        chk("lit_b2b_q", 32'(q_reg), ROT_EN ? 32'(4'b1001) : 32'(4'b0011));

        // Randomized traffic; an unaccepted command is held by the source
        cmd_valid = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!cmd_valid || last_acc) begin
                cmd_valid = ($urandom_range(0, 9) < 7);
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_data  = W'($urandom);
                cmd_count = CW'($urandom);
                cmd_fill  = 1'($urandom);
            end
            Clear = ($urandom_range(0, 59) == 0);
            cycle();
        end
        cmd_valid = 1'b0;
        Clear = 1'b0;
        for (int i = 0; i < 12; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
